// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  function automatic int bytes_per_word(input int instr_width);
    return instr_width / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port and boot status.
interface imem_loader_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10
);
  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   start;
  logic                   imem_we;
  logic [ADDR_WIDTH-1:0]  imem_waddr;
  logic [INSTR_WIDTH-1:0] imem_wdata;
  logic                   cpu_hold;
  logic                   load_done;
  logic                   load_err;
  logic [15:0]            words_written;

  modport slave (
    input  s_data, s_valid, start,
    output s_ready, imem_we, imem_waddr, imem_wdata,
    output cpu_hold, load_done, load_err, words_written
  );

  modport master (
    output s_data, s_valid, start,
    input  s_ready, imem_we, imem_waddr, imem_wdata,
    input  cpu_hold, load_done, load_err, words_written
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembly; o_word is combinational so the
// completed word is available on the edge that accepts its last lane.
module imem_loader_word_packer
  import imem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_byte_vld,
  input  logic [7:0]             i_byte,
  output logic                   o_word_ready,
  output logic [INSTR_WIDTH-1:0] o_word
);
  localparam int BPW    = bytes_per_word(INSTR_WIDTH);
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  logic [LANE_W-1:0]      r_lane;
  logic [INSTR_WIDTH-1:0] r_word;
  logic [INSTR_WIDTH-1:0] w_word;

  always_comb begin
    w_word = r_word;
    w_word[{r_lane, 3'b000} +: 8] = i_byte;
  end

  assign o_word_ready = i_byte_vld && (r_lane == LAST_LANE);
  assign o_word       = w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_byte_vld) begin
      r_word <= w_word;
      r_lane <= o_word_ready ? '0 : r_lane + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC, 16-bit word count, payload and XOR checksum,
// writing words from address 0 and releasing cpu_hold on a clean frame.
//   state   | meaning
//   IDLE    | hunting for MAGIC, other bytes dropped
//   LEN_LO  | expecting word count bits [7:0]
//   LEN_HI  | expecting word count bits [15:8], range check
//   PAYLOAD | packing bytes into words, writing memory
//   CHECK   | expecting checksum byte
//   DONE    | frame good, CPU released, waiting for start
//   ERROR   | frame rejected, CPU held, waiting for start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         INSTR_WIDTH = 32,
  parameter int         ADDR_WIDTH  = 10,
  parameter logic [7:0] MAGIC       = MAGIC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                 r_state, w_state_nxt;
  logic [15:0]            r_len;
  logic [ADDR_WIDTH:0]    r_wcnt;
  logic [7:0]             r_csum;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [INSTR_WIDTH-1:0] r_wdata;
  logic                   r_hold;
  logic                   r_done;
  logic                   r_err;
  logic [15:0]            r_words;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_rearm;
  logic [15:0]            w_len_new;
  logic                   w_len_bad;
  logic                   w_last_word;
  logic                   w_pack_vld;
  logic                   w_word_ready;
  logic [INSTR_WIDTH-1:0] w_word;

  assign w_ready     = (r_state != DONE) && (r_state != ERROR);
  assign w_accept    = bus.s_valid && w_ready;
  assign w_rearm     = bus.start && !w_ready;
  assign w_len_new   = {bus.s_data, r_len[7:0]};
  assign w_len_bad   = {1'b0, w_len_new} > MAX_WORDS;
  assign w_last_word = (16'(r_wcnt) + 16'd1) == r_len;
  assign w_pack_vld  = w_accept && (r_state == PAYLOAD);

  imem_loader_word_packer #(.INSTR_WIDTH(INSTR_WIDTH)) u_word_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_rearm),
    .i_byte_vld   (w_pack_vld),
    .i_byte       (bus.s_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && bus.s_data == MAGIC) w_state_nxt = LEN_LO;
      LEN_LO:  if (w_accept) w_state_nxt = LEN_HI;
      LEN_HI:
        if (w_accept) begin
          if (w_len_bad)               w_state_nxt = ERROR;
          else if (w_len_new == 16'd0) w_state_nxt = CHECK;
          else                         w_state_nxt = PAYLOAD;
        end
      PAYLOAD: if (w_word_ready && w_last_word) w_state_nxt = CHECK;
      CHECK:   if (w_accept) w_state_nxt = (bus.s_data == r_csum) ? DONE : ERROR;
      DONE,
      ERROR:   if (bus.start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_wcnt  <= '0;
      r_csum  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_rearm) begin
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_words <= '0;
        r_csum  <= '0;
        r_wcnt  <= '0;
        r_hold  <= 1'b1;
      end else if (w_accept) begin
        unique case (r_state)
          LEN_LO: r_len[7:0] <= bus.s_data;
          LEN_HI: begin
            r_len[15:8] <= bus.s_data;
            if (w_len_bad) r_err <= 1'b1;
          end
          PAYLOAD: begin
            r_csum <= r_csum ^ bus.s_data;
            if (w_word_ready) begin
              r_wdata <= w_word;
              r_waddr <= r_wcnt[ADDR_WIDTH-1:0];
              r_we    <= 1'b1;
              r_wcnt  <= r_wcnt + 1'b1;
              r_words <= r_words + 16'd1;
            end
          end
          CHECK: begin
            if (bus.s_data == r_csum) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.s_ready       = w_ready;
  assign bus.imem_we       = r_we;
  assign bus.imem_waddr    = r_waddr;
  assign bus.imem_wdata    = r_wdata;
  assign bus.cpu_hold      = r_hold;
  assign bus.load_done     = r_done;
  assign bus.load_err      = r_err;
  assign bus.words_written = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame-level reference model checked every
// cycle, plus literal expectations for memory contents and status flags.
module tb_imem_loader;
  localparam int IW  = 32;
  localparam int AW  = 10;
  localparam int BPW = IW / 8;

  localparam int HUNT = 0, LEN0 = 1, LEN1 = 2, BODY = 3, SUM = 4, OK = 5, BAD = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  imem_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .MAGIC(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: payload bytes kept as a list, words and checksum
  // derived from that list.
  int          m_ph;
  int          m_len;
  logic [7:0]  m_pay[$];
  logic        m_we;
  logic [AW-1:0] m_waddr;
  logic [31:0] m_wdata;
  logic        m_hold, m_done, m_err;
  logic [7:0]  mb;
  int          mx, mw;

  function automatic logic m_ready();
    return !(m_ph == OK || m_ph == BAD);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ph = HUNT; m_len = 0; m_pay.delete();
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
      end else begin
        m_we = 1'b0;
        if (!m_ready()) begin
          if (bus.start) begin
            m_ph = HUNT; m_pay.delete();
            m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
          end
        end else if (bus.s_valid) begin
          mb = bus.s_data;
          case (m_ph)
            HUNT: if (mb == 8'hA5) m_ph = LEN0;
            LEN0: begin m_len = int'(mb); m_ph = LEN1; end
            LEN1: begin
              m_len = m_len + int'(mb) * 256;
              if (m_len > (1 << AW)) begin m_ph = BAD; m_err = 1'b1; end
              else if (m_len == 0)   m_ph = SUM;
              else                   m_ph = BODY;
            end
            BODY: begin
              m_pay.push_back(mb);
              if (m_pay.size() % BPW == 0) begin
                mw = m_pay.size() / BPW - 1;
                m_wdata = '0;
                for (int k = 0; k < BPW; k++)
                  m_wdata = m_wdata | (32'(m_pay[mw*BPW + k]) << (8*k));
                m_waddr = AW'(mw);
                m_we = 1'b1;
              end
              if (m_pay.size() == m_len * BPW) m_ph = SUM;
            end
            SUM: begin
              mx = 0;
              foreach (m_pay[i]) mx = mx ^ int'(m_pay[i]);
              if (mb == mx[7:0]) begin m_ph = OK; m_hold = 1'b0; m_done = 1'b1; end
              else begin m_ph = BAD; m_err = 1'b1; end
            end
            default: ;
          endcase
        end
      end
    end
  end

  int          wr_seen = 0;
  logic [31:0] tb_mem [0:(1<<AW)-1];

  initial begin
    forever begin
      @(negedge clk);
      chk("s_ready",       32'(bus.s_ready),       32'(m_ready()));
      chk("cpu_hold",      32'(bus.cpu_hold),      32'(m_hold));
      chk("load_done",     32'(bus.load_done),     32'(m_done));
      chk("load_err",      32'(bus.load_err),      32'(m_err));
      chk("imem_we",       32'(bus.imem_we),       32'(m_we));
      chk("words_written", 32'(bus.words_written), m_pay.size() / BPW);
      if (m_we) begin
        chk("imem_waddr", 32'(bus.imem_waddr), 32'(m_waddr));
        chk("imem_wdata", bus.imem_wdata,      m_wdata);
      end
      if (bus.imem_we) begin
        wr_seen++;
        tb_mem[bus.imem_waddr] = bus.imem_wdata;
      end
    end
  end

  logic [7:0] fq[$];

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_wait: s_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_frame(input int max_gap);
    foreach (fq[i]) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(negedge clk);
          bus.s_valid = 1'b0;
        end
      end
      send(fq[i]);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  int w0;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.start   = 1'b0;
    for (int i = 0; i < (1 << AW); i++) tb_mem[i] = 32'h0;

    // 1: reset, idle, start ignored outside DONE/ERROR
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    pulse_start();
    idle(2);
    chk("t1_cpu_hold",  32'(bus.cpu_hold),  1);
    chk("t1_s_ready",   32'(bus.s_ready),   1);
    chk("t1_load_done", 32'(bus.load_done), 0);
    chk("t1_writes",    wr_seen,            0);

    // 2: two-word load; payload XOR 13^93^10 = 90
    fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(0);
    idle(2);
    chk("t2_mem0",      tb_mem[0],               32'h0000_0013);
    chk("t2_mem1",      tb_mem[1],               32'h0010_0093);
    chk("t2_writes",    wr_seen,                 2);
    chk("t2_load_done", 32'(bus.load_done),      1);
    chk("t2_cpu_hold",  32'(bus.cpu_hold),       0);
    chk("t2_words",     32'(bus.words_written),  2);
    chk("t2_s_ready",   32'(bus.s_ready),        0);

    // 3: bad checksum, then re-arm
    pulse_start();
    w0 = wr_seen;
    fq[11] = 8'h81;
    send_frame(0);
    idle(2);
    chk("t3_writes",    wr_seen - w0,       2);
    chk("t3_load_err",  32'(bus.load_err),  1);
    chk("t3_load_done", 32'(bus.load_done), 0);
    chk("t3_cpu_hold",  32'(bus.cpu_hold),  1);
    pulse_start();
    idle(1);
    chk("t3_rearm_err",   32'(bus.load_err),      0);
    chk("t3_rearm_ready", 32'(bus.s_ready),       1);
    chk("t3_rearm_words", 32'(bus.words_written), 0);

    // 4: garbage then oversize count 0x0401
    w0 = wr_seen;
    fq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h04};
    send_frame(0);
    idle(2);
    chk("t4_writes",   wr_seen - w0,      0);
    chk("t4_load_err", 32'(bus.load_err), 1);
    chk("t4_cpu_hold", 32'(bus.cpu_hold), 1);
    pulse_start();

    // 5a: zero-length frame, checksum of nothing is 00
    w0 = wr_seen;
    fq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    idle(2);
    chk("t5a_writes",    wr_seen - w0,       0);
    chk("t5a_load_done", 32'(bus.load_done), 1);
    chk("t5a_cpu_hold",  32'(bus.cpu_hold),  0);
    pulse_start();

    // 5b: two-word load with random valid gaps
    tb_mem[0] = 32'h0;
    tb_mem[1] = 32'h0;
    w0 = wr_seen;
    fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(3);
    idle(2);
    chk("t5b_mem0",      tb_mem[0],          32'h0000_0013);
    chk("t5b_mem1",      tb_mem[1],          32'h0010_0093);
    chk("t5b_writes",    wr_seen - w0,       2);
    chk("t5b_load_done", 32'(bus.load_done), 1);
    pulse_start();

    // 6: reset after six bytes, then a one-word frame EF^BE^AD^DE = 22
    fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_frame(0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_hold",  32'(bus.cpu_hold),      1);
    chk("t6_rst_we",    32'(bus.imem_we),       0);
    chk("t6_rst_waddr", 32'(bus.imem_waddr),    0);
    chk("t6_rst_wdata", bus.imem_wdata,         0);
    chk("t6_rst_done",  32'(bus.load_done),     0);
    chk("t6_rst_err",   32'(bus.load_err),      0);
    chk("t6_rst_words", 32'(bus.words_written), 0);
    chk("t6_rst_ready", 32'(bus.s_ready),       1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_seen;
    fq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_frame(0);
    idle(2);
    chk("t6_mem0",      tb_mem[0],              32'hDEAD_BEEF);
    chk("t6_mem1",      tb_mem[1],              32'h0010_0093);
    chk("t6_writes",    wr_seen - w0,           1);
    chk("t6_words",     32'(bus.words_written), 1);
    chk("t6_load_done", 32'(bus.load_done),     1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
